// File: rtl/div64x32_seq.sv
// div64x32_seq
// Sequential unsigned 64-by-32 divider using restoring shift-subtract
// division, one quotient bit per clock, MSB first.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   start      begin a division (only looked at while idle)
//   a          64-bit unsigned dividend, captured on the accepted start edge
//   b          32-bit unsigned divisor, captured on the accepted start edge
//   busy       high while a division is in flight
//   quotient   quotient of the last completed division
//   remainder  remainder of the last completed division
//   overflow   last division had b==0 or a[63:32] >= b (quotient won't fit)
module div64x32_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        overflow
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t      state;
  state_t      state_next;
  logic [4:0]  step_cnt;
  logic [31:0] rem_q;
  logic [31:0] low_q;
  logic [31:0] div_q;
  logic        ovf_pending;

  logic [32:0] partial;
  logic        qbit;
  logic [32:0] rem_next;

  // One restoring step: shift the next dividend bit into the 33-bit partial
  // remainder, and subtract the divisor when it fits. The running remainder
  // is always below the divisor, so it fits back into 32 bits.
  always_comb begin
    partial  = {rem_q, low_q[31]};
    qbit     = (partial >= {1'b0, div_q});
    rem_next = qbit ? (partial - {1'b0, div_q}) : partial;
  end

  // State register; reset wins over everything, including a pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: an overflowing request spends a single cycle in CALC,
  // a normal one spends ITER cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (ovf_pending || (step_cnt == LAST_STEP)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state == CALC);
  end

  // Datapath. Operands are captured on the start edge; low_q holds the
  // not-yet-consumed dividend bits and fills with quotient bits from the
  // bottom. Result registers only change when an operation completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt    <= '0;
      rem_q       <= '0;
      low_q       <= '0;
      div_q       <= '0;
      ovf_pending <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_q       <= a[63:32];
            low_q       <= a[31:0];
            div_q       <= b;
            step_cnt    <= '0;
            ovf_pending <= (b == 32'd0) || (a[63:32] >= b);
          end
        end
        CALC: begin
          if (ovf_pending) begin
            quotient  <= 32'hFFFF_FFFF;
            remainder <= 32'h0;
            overflow  <= 1'b1;
          end else begin
            rem_q    <= rem_next[31:0];
            low_q    <= {low_q[30:0], qbit};
            step_cnt <= step_cnt + 5'd1;
            if (step_cnt == LAST_STEP) begin
              quotient  <= {low_q[30:0], qbit};
              remainder <= rem_next[31:0];
              overflow  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div64x32_seq.sv
// Testbench for div64x32_seq: directed vectors with hand-computed results.
module tb_div64x32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  div64x32_seq #(.ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Counts negedges with busy high; bounded so a stuck DUT still terminates.
  task automatic countBusy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // One-cycle start pulse, then wait for completion and check everything.
  task automatic applyStimulus(input string tag, input logic [63:0] av,
                               input logic [31:0] bv, input int expBusy,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expO);
    int cyc;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    countBusy(cyc);
    checkOutput({tag, " busy cycles"}, 64'(cyc), 64'(expBusy));
    checkOutput({tag, " quotient"}, 64'(quotient), 64'(expQ));
    checkOutput({tag, " remainder"}, 64'(remainder), 64'(expR));
    checkOutput({tag, " overflow"}, 64'(overflow), 64'(expO));
  endtask

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int lowCyc;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    // Reset for 4 cycles, then everything must read zero.
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset quotient", 64'(quotient), 64'd0);
    checkOutput("reset remainder", 64'(remainder), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    reset = 1'b0;

    // Basic division.
    applyStimulus("100/7", 64'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);

    // Large exact product, then off by 7.
    applyStimulus("exact", 64'd97893587989061755, 32'd316276955, 32,
                  32'd309518561, 32'd0, 1'b0);
    applyStimulus("exact+7", 64'd97893587989061762, 32'd316276955, 32,
                  32'd309518561, 32'd7, 1'b0);

    // Overflow: divide by zero, then high half equal to the divisor.
    applyStimulus("div0", 64'd1234, 32'd0, 1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    applyStimulus("hi>=b", 64'd5 << 32, 32'd5, 1, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Start pulse and operand changes mid-operation must be ignored, and
    // results from the previous (overflow) op must hold while busy.
    @(negedge clk);
    a = 64'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    a = 64'd9;
    b = 32'd3;
    start = 1'b1;
    checkOutput("hold quotient", 64'(quotient), 64'hFFFF_FFFF);
    checkOutput("hold overflow", 64'(overflow), 64'd1);
    @(negedge clk);
    start = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 32'd1;
    countBusy(cyc);
    checkOutput("ignore busy cycles", 64'(cyc + 10), 64'd32);
    checkOutput("ignore quotient", 64'(quotient), 64'd14);
    checkOutput("ignore remainder", 64'(remainder), 64'd2);

    // Reset aborts an in-flight division; a start during reset is dropped.
    applyStimulus("pre-abort", 64'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    a = 64'd50;
    b = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort quotient", 64'(quotient), 64'd0);
    checkOutput("abort remainder", 64'(remainder), 64'd0);
    checkOutput("abort overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("start-in-reset busy", 64'(busy), 64'd0);
    applyStimulus("50/6", 64'd50, 32'd6, 32, 32'd8, 32'd2, 1'b0);

    // Start held high: back-to-back operations, 32 busy + 1 idle each.
    @(negedge clk);
    a = 64'd1000;
    b = 32'd10;
    start = 1'b1;
    @(negedge clk);
    for (int op = 0; op < 3; op++) begin
      countBusy(cyc);
      checkOutput($sformatf("b2b%0d busy cycles", op), 64'(cyc), 64'd32);
      checkOutput($sformatf("b2b%0d quotient", op), 64'(quotient), 64'd100);
      checkOutput($sformatf("b2b%0d remainder", op), 64'(remainder), 64'd0);
      lowCyc = 0;
      while (busy !== 1'b1 && lowCyc < 10) begin
        lowCyc++;
        @(negedge clk);
      end
      checkOutput($sformatf("b2b%0d idle cycles", op), 64'(lowCyc), 64'd1);
    end
    start = 1'b0;
    countBusy(cyc);
    checkOutput("b2b final quotient", 64'(quotient), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
